// File: rtl/bufpool_xbar.sv
// Agent/buffer crossbar for the packet memory: owns per-buffer lifecycle, in-order
// ring pointers and request/grant handshakes for snooper, CPU and forwarder.
//
// state    | meaning
// ---------+-------------------------------------------------
// EMPTY    | free, next candidate for the snooper
// SN       | owned by snooper, being written
// FULL     | packet complete, waiting for the CPU
// CPU      | owned by CPU, being inspected
// PASS     | accepted, waiting for the forwarder
// DROP     | rejected, reclaimed when fwd_ptr reaches it
// FWD      | owned by forwarder, being sent
module bufpool_xbar #(
  parameter int N_BUFS     = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int WR_WIDTH   = 64,
  parameter int RD_WIDTH   = 64,
  parameter int PLEN_WIDTH = 32,
  localparam int IDX_W = $clog2(N_BUFS),
  localparam int CNT_W = $clog2(N_BUFS+1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     sn_req,
  output logic                                     sn_gnt,
  input  logic                                     sn_done,
  input  logic [ADDR_WIDTH+WR_WIDTH:0]             from_sn,
  input  logic                                     cpu_req,
  output logic                                     cpu_gnt,
  input  logic                                     cpu_acc,
  input  logic                                     cpu_rej,
  input  logic [ADDR_WIDTH:0]                      from_cpu,
  output logic [RD_WIDTH+PLEN_WIDTH-1:0]           to_cpu,
  input  logic                                     fwd_req,
  output logic                                     fwd_gnt,
  input  logic                                     fwd_done,
  input  logic [ADDR_WIDTH:0]                      from_fwd,
  output logic [RD_WIDTH+PLEN_WIDTH-1:0]           to_fwd,
  output logic [N_BUFS*(ADDR_WIDTH+WR_WIDTH+2)-1:0] to_bufs,
  input  logic [N_BUFS*(RD_WIDTH+PLEN_WIDTH)-1:0]  from_bufs,
  output logic [CNT_W-1:0]                         n_full
);

  localparam int BW = ADDR_WIDTH + WR_WIDTH + 2;
  localparam int RW = RD_WIDTH + PLEN_WIDTH;

  typedef enum logic [2:0] {
    ST_EMPTY, ST_SN, ST_FULL, ST_CPU, ST_PASS, ST_DROP, ST_FWD
  } buf_state_t;

  buf_state_t st_q [N_BUFS];
  buf_state_t st_d [N_BUFS];

  logic [IDX_W-1:0] sn_ptr, cpu_ptr, fwd_ptr;
  logic [IDX_W-1:0] sn_ptr_d, cpu_ptr_d, fwd_ptr_d;
  logic             sn_gnt_d, cpu_gnt_d, fwd_gnt_d;
  logic [CNT_W-1:0] n_full_d;

  buf_state_t st_at_sn, st_at_cpu, st_at_fwd;
  logic       sn_grant, sn_rel, cpu_grant, cpu_rel, fwd_grant, fwd_rel, reclaim;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(N_BUFS-1)) ? '0 : p + IDX_W'(1);
  endfunction

  // Mux out the state each pointer currently looks at.
  always_comb begin
    st_at_sn  = ST_EMPTY;
    st_at_cpu = ST_EMPTY;
    st_at_fwd = ST_EMPTY;
    for (int i = 0; i < N_BUFS; i++) begin
      if (sn_ptr  == IDX_W'(i)) st_at_sn  = st_q[i];
      if (cpu_ptr == IDX_W'(i)) st_at_cpu = st_q[i];
      if (fwd_ptr == IDX_W'(i)) st_at_fwd = st_q[i];
    end
  end

  always_comb begin
    sn_grant  = sn_req  && !sn_gnt  && (st_at_sn  == ST_EMPTY);
    sn_rel    = sn_done && sn_gnt;
    cpu_grant = cpu_req && !cpu_gnt && (st_at_cpu == ST_FULL);
    cpu_rel   = (cpu_acc || cpu_rej) && cpu_gnt;
    fwd_grant = fwd_req && !fwd_gnt && (st_at_fwd == ST_PASS);
    fwd_rel   = fwd_done && fwd_gnt;
    reclaim   = !fwd_gnt && (st_at_fwd == ST_DROP);
  end

  // Every event targets a buffer in a distinct state, so they never collide.
  always_comb begin
    for (int i = 0; i < N_BUFS; i++) begin
      st_d[i] = st_q[i];
      if (sn_ptr == IDX_W'(i)) begin
        if (sn_grant)    st_d[i] = ST_SN;
        else if (sn_rel) st_d[i] = ST_FULL;
      end
      if (cpu_ptr == IDX_W'(i)) begin
        if (cpu_grant)    st_d[i] = ST_CPU;
        else if (cpu_rel) st_d[i] = cpu_rej ? ST_DROP : ST_PASS;
      end
      if (fwd_ptr == IDX_W'(i)) begin
        if (fwd_grant)              st_d[i] = ST_FWD;
        else if (fwd_rel || reclaim) st_d[i] = ST_EMPTY;
      end
    end

    sn_gnt_d  = sn_grant  ? 1'b1 : (sn_rel  ? 1'b0 : sn_gnt);
    cpu_gnt_d = cpu_grant ? 1'b1 : (cpu_rel ? 1'b0 : cpu_gnt);
    fwd_gnt_d = fwd_grant ? 1'b1 : (fwd_rel ? 1'b0 : fwd_gnt);

    sn_ptr_d  = sn_rel  ? ptr_inc(sn_ptr)  : sn_ptr;
    cpu_ptr_d = cpu_rel ? ptr_inc(cpu_ptr) : cpu_ptr;
    fwd_ptr_d = (fwd_rel || reclaim) ? ptr_inc(fwd_ptr) : fwd_ptr;

    n_full_d = '0;
    for (int i = 0; i < N_BUFS; i++) begin
      if (st_d[i] == ST_FULL) n_full_d = n_full_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BUFS; i++) st_q[i] <= ST_EMPTY;
      sn_ptr  <= '0;
      cpu_ptr <= '0;
      fwd_ptr <= '0;
      sn_gnt  <= 1'b0;
      cpu_gnt <= 1'b0;
      fwd_gnt <= 1'b0;
      n_full  <= '0;
    end else begin
      for (int i = 0; i < N_BUFS; i++) st_q[i] <= st_d[i];
      sn_ptr  <= sn_ptr_d;
      cpu_ptr <= cpu_ptr_d;
      fwd_ptr <= fwd_ptr_d;
      sn_gnt  <= sn_gnt_d;
      cpu_gnt <= cpu_gnt_d;
      fwd_gnt <= fwd_gnt_d;
      n_full  <= n_full_d;
    end
  end

  // Buffer-side mux: each slice is steered by its owner, idle buffers see zeros.
  always_comb begin
    to_bufs = '0;
    for (int i = 0; i < N_BUFS; i++) begin
      case (st_q[i])
        ST_SN:   to_bufs[i*BW +: BW] = {from_sn, 1'b0};
        ST_CPU:  to_bufs[i*BW +: BW] = {from_cpu[ADDR_WIDTH:1], {WR_WIDTH{1'b0}}, 1'b0, from_cpu[0]};
        ST_FWD:  to_bufs[i*BW +: BW] = {from_fwd[ADDR_WIDTH:1], {WR_WIDTH{1'b0}}, 1'b0, from_fwd[0]};
        default: to_bufs[i*BW +: BW] = '0;
      endcase
    end
  end

  always_comb begin
    to_cpu = '0;
    to_fwd = '0;
    for (int i = 0; i < N_BUFS; i++) begin
      if (cpu_gnt && cpu_ptr == IDX_W'(i)) to_cpu = from_bufs[i*RW +: RW];
      if (fwd_gnt && fwd_ptr == IDX_W'(i)) to_fwd = from_bufs[i*RW +: RW];
    end
  end

endmodule

// File: tb/tb_bufpool_xbar.sv
// Bench for bufpool_xbar: directed cycle table on a 3-buffer instance plus a
// 20-packet accept/reject ordering run on a 5-buffer instance.
module tb_bufpool_xbar;

  localparam int BW = 76;
  localparam int RW = 96;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 3-buffer instance ----------------
  logic          rst, sn_req, sn_gnt, sn_done, cpu_req, cpu_gnt, cpu_acc, cpu_rej;
  logic          fwd_req, fwd_gnt, fwd_done;
  logic [74:0]   from_sn;
  logic [10:0]   from_cpu, from_fwd;
  logic [95:0]   to_cpu, to_fwd;
  logic [3*BW-1:0] to_bufs;
  logic [3*RW-1:0] from_bufs;
  logic [1:0]    n_full;

  bufpool_xbar #(.N_BUFS(3)) dut3 (
    .clk(clk), .rst(rst),
    .sn_req(sn_req), .sn_gnt(sn_gnt), .sn_done(sn_done), .from_sn(from_sn),
    .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .cpu_acc(cpu_acc), .cpu_rej(cpu_rej),
    .from_cpu(from_cpu), .to_cpu(to_cpu),
    .fwd_req(fwd_req), .fwd_gnt(fwd_gnt), .fwd_done(fwd_done),
    .from_fwd(from_fwd), .to_fwd(to_fwd),
    .to_bufs(to_bufs), .from_bufs(from_bufs), .n_full(n_full)
  );

  always_comb begin
    for (int i = 0; i < 3; i++) from_bufs[i*RW +: RW] = {64'hA0 + 64'(i), 32'(100 + i)};
  end

  // ---------------- 5-buffer instance ----------------
  logic          r_rst, r_sn_req, r_sn_gnt, r_sn_done, r_cpu_req, r_cpu_gnt, r_cpu_acc, r_cpu_rej;
  logic          r_fwd_req, r_fwd_gnt, r_fwd_done;
  logic [74:0]   r_from_sn;
  logic [10:0]   r_from_cpu, r_from_fwd;
  logic [95:0]   r_to_cpu, r_to_fwd;
  logic [5*BW-1:0] r_to_bufs;
  logic [5*RW-1:0] r_from_bufs;
  logic [2:0]    r_n_full;
  logic [63:0]   mem5 [5];

  bufpool_xbar #(.N_BUFS(5)) dut5 (
    .clk(clk), .rst(r_rst),
    .sn_req(r_sn_req), .sn_gnt(r_sn_gnt), .sn_done(r_sn_done), .from_sn(r_from_sn),
    .cpu_req(r_cpu_req), .cpu_gnt(r_cpu_gnt), .cpu_acc(r_cpu_acc), .cpu_rej(r_cpu_rej),
    .from_cpu(r_from_cpu), .to_cpu(r_to_cpu),
    .fwd_req(r_fwd_req), .fwd_gnt(r_fwd_gnt), .fwd_done(r_fwd_done),
    .from_fwd(r_from_fwd), .to_fwd(r_to_fwd),
    .to_bufs(r_to_bufs), .from_bufs(r_from_bufs), .n_full(r_n_full)
  );

  // Simple buffer memory model: one data word per buffer.
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (r_to_bufs[i*BW+1]) mem5[i] <= r_to_bufs[i*BW+2 +: 64];
  end

  always_comb begin
    for (int i = 0; i < 5; i++) r_from_bufs[i*RW +: RW] = {mem5[i], 32'(i)};
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] en_mask3();
    logic [2:0] m;
    for (int i = 0; i < 3; i++) m[i] = |to_bufs[i*BW +: 2];
    return m;
  endfunction

  // inputs: {rst, sn_req, sn_done, cpu_req, cpu_acc, cpu_rej, fwd_req, fwd_done}
  // gnts:   {sn_gnt, cpu_gnt, fwd_gnt}
  typedef struct packed {
    logic [7:0] in;
    logic [2:0] gnt;
    logic [1:0] nf;
    logic [2:0] mask;
  } vec_t;

  function automatic vec_t v(input logic [7:0] in, input logic [2:0] g,
                             input logic [1:0] nf, input logic [2:0] m);
    vec_t r;
    r.in = in; r.gnt = g; r.nf = nf; r.mask = m;
    return r;
  endfunction

  vec_t tbl [37];

  task automatic drive_in(input logic [7:0] in);
    {rst, sn_req, sn_done, cpu_req, cpu_acc, cpu_rej, fwd_req, fwd_done} = in;
  endtask

  task automatic step3(input logic [7:0] in);
    @(negedge clk);
    drive_in(in);
    @(posedge clk);
    #1;
  endtask

  logic [63:0] wdat [5];
  logic [63:0] q [$];
  int nacc, nfwd;
  logic got, acc;
  logic [63:0] data;

  initial begin
    // lifecycle: snoop -> full -> cpu accept -> fwd -> empty; reject; acc+rej; spurious
    // pulses; saturation and wrap; reset with all agents granted
    tbl[0]  = v(8'b0100_0000, 3'b100, 2'd0, 3'b001);
    tbl[1]  = v(8'b0000_0000, 3'b100, 2'd0, 3'b001);
    tbl[2]  = v(8'b0010_0000, 3'b000, 2'd1, 3'b000);
    tbl[3]  = v(8'b0001_0000, 3'b010, 2'd0, 3'b001);
    tbl[4]  = v(8'b0000_1000, 3'b000, 2'd0, 3'b000);
    tbl[5]  = v(8'b0000_0010, 3'b001, 2'd0, 3'b001);
    tbl[6]  = v(8'b0000_0001, 3'b000, 2'd0, 3'b000);
    tbl[7]  = v(8'b0100_0000, 3'b100, 2'd0, 3'b010);
    tbl[8]  = v(8'b0010_0000, 3'b000, 2'd1, 3'b000);
    tbl[9]  = v(8'b0001_0000, 3'b010, 2'd0, 3'b010);
    tbl[10] = v(8'b0000_0100, 3'b000, 2'd0, 3'b000);
    tbl[11] = v(8'b0000_0000, 3'b000, 2'd0, 3'b000);
    tbl[12] = v(8'b0100_0000, 3'b100, 2'd0, 3'b100);
    tbl[13] = v(8'b0010_0000, 3'b000, 2'd1, 3'b000);
    tbl[14] = v(8'b0001_0000, 3'b010, 2'd0, 3'b100);
    tbl[15] = v(8'b0000_1110, 3'b000, 2'd0, 3'b000);
    tbl[16] = v(8'b0000_0010, 3'b000, 2'd0, 3'b000);
    tbl[17] = v(8'b0000_0010, 3'b000, 2'd0, 3'b000);
    tbl[18] = v(8'b0010_1001, 3'b000, 2'd0, 3'b000);
    tbl[19] = v(8'b0100_0000, 3'b100, 2'd0, 3'b001);
    tbl[20] = v(8'b0010_0000, 3'b000, 2'd1, 3'b000);
    tbl[21] = v(8'b0100_0000, 3'b100, 2'd1, 3'b010);
    tbl[22] = v(8'b0010_0000, 3'b000, 2'd2, 3'b000);
    tbl[23] = v(8'b0100_0000, 3'b100, 2'd2, 3'b100);
    tbl[24] = v(8'b0010_0000, 3'b000, 2'd3, 3'b000);
    tbl[25] = v(8'b0100_0000, 3'b000, 2'd3, 3'b000);
    tbl[26] = v(8'b0101_0000, 3'b010, 2'd2, 3'b001);
    tbl[27] = v(8'b0100_1000, 3'b000, 2'd2, 3'b000);
    tbl[28] = v(8'b0101_0010, 3'b011, 2'd1, 3'b011);
    tbl[29] = v(8'b0101_0001, 3'b010, 2'd1, 3'b010);
    tbl[30] = v(8'b0101_0000, 3'b110, 2'd1, 3'b011);
    tbl[31] = v(8'b0000_1000, 3'b100, 2'd1, 3'b001);
    tbl[32] = v(8'b0001_0010, 3'b111, 2'd0, 3'b111);
    tbl[33] = v(8'b1000_0000, 3'b000, 2'd0, 3'b000);
    tbl[34] = v(8'b0101_0010, 3'b100, 2'd0, 3'b001);
    tbl[35] = v(8'b0010_0000, 3'b000, 2'd1, 3'b000);
    tbl[36] = v(8'b0001_0000, 3'b010, 2'd0, 3'b001);

    drive_in(8'b1000_0000);
    from_sn = {10'd5, 64'hDEAD_BEEF, 1'b1};
    from_cpu = {10'd7, 1'b1};
    from_fwd = {10'd9, 1'b1};
    r_rst = 1'b1;
    {r_sn_req, r_sn_done, r_cpu_req, r_cpu_acc, r_cpu_rej, r_fwd_req, r_fwd_done} = '0;
    r_from_sn = '0; r_from_cpu = {10'd3, 1'b1}; r_from_fwd = {10'd4, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnts", {sn_gnt, cpu_gnt, fwd_gnt}, 3'b000);
    chk("reset n_full", n_full, 2'd0);
    chk("reset to_bufs", to_bufs, '0);
    chk("reset to_cpu", to_cpu, '0);
    chk("reset to_fwd", to_fwd, '0);

    // Datapath details on buffer 0.
    step3(8'b0100_0000);
    chk("sn slice0", to_bufs[0 +: BW], {10'd5, 64'hDEAD_BEEF, 1'b1, 1'b0});
    chk("sn slices1-2", to_bufs[BW +: 2*BW], '0);
    step3(8'b0010_0000);
    chk("n_full after sn_done", n_full, 2'd1);
    step3(8'b0001_0000);
    chk("cpu slice0", to_bufs[0 +: BW], {10'd7, 64'h0, 1'b0, 1'b1});
    chk("to_cpu", to_cpu, {64'hA0, 32'd100});
    chk("to_fwd idle", to_fwd, '0);
    step3(8'b0000_1000);
    step3(8'b0000_0010);
    chk("fwd slice0", to_bufs[0 +: BW], {10'd9, 64'h0, 1'b0, 1'b1});
    chk("to_fwd", to_fwd, {64'hA0, 32'd100});
    chk("to_cpu after release", to_cpu, '0);
    step3(8'b0000_0001);
    step3(8'b1000_0000);

    for (int i = 0; i < 37; i++) begin
      step3(tbl[i].in);
      chk($sformatf("row%0d gnt", i), {sn_gnt, cpu_gnt, fwd_gnt}, tbl[i].gnt);
      chk($sformatf("row%0d n_full", i), n_full, tbl[i].nf);
      chk($sformatf("row%0d en_mask", i), en_mask3(), tbl[i].mask);
    end
    drive_in(8'b0000_0000);

    // 5-buffer ordering run: 4 rounds of 5 packets with random accept/reject.
    @(negedge clk);
    r_rst = 1'b0;
    nacc = 0;
    nfwd = 0;
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int k = 0; k < 5; k++) begin
        data = {$urandom, $urandom};
        wdat[k] = data;
        @(negedge clk);
        r_sn_req = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
          @(posedge clk); #1; got = r_sn_gnt;
        end
        if (!got) chk("r sn_gnt timeout", 1'b0, 1'b1);
        @(negedge clk);
        r_sn_req = 1'b0;
        r_from_sn = {10'(k), data, 1'b1};
        @(negedge clk);
        r_from_sn = '0;
        r_sn_done = 1'b1;
        @(negedge clk);
        r_sn_done = 1'b0;
      end
      chk("r n_full round", r_n_full, 3'd5);
      for (int k = 0; k < 5; k++) begin
        r_cpu_req = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
          @(posedge clk); #1; got = r_cpu_gnt;
        end
        if (!got) chk("r cpu_gnt timeout", 1'b0, 1'b1);
        chk("r to_cpu data", r_to_cpu[95:32], wdat[k]);
        @(negedge clk);
        r_cpu_req = 1'b0;
        acc = 1'($urandom_range(0, 1));
        if (acc) begin
          r_cpu_acc = 1'b1;
          q.push_back(wdat[k]);
          nacc++;
        end else begin
          r_cpu_rej = 1'b1;
        end
        @(negedge clk);
        r_cpu_acc = 1'b0;
        r_cpu_rej = 1'b0;
      end
      while (q.size() > 0) begin
        r_fwd_req = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
          @(posedge clk); #1; got = r_fwd_gnt;
        end
        if (!got) begin
          chk("r fwd_gnt timeout", 1'b0, 1'b1);
          q.delete();
        end else begin
          chk("r to_fwd order", r_to_fwd[95:32], q.pop_front());
          nfwd++;
        end
        @(negedge clk);
        r_fwd_req = 1'b0;
        r_fwd_done = got;
        @(negedge clk);
        r_fwd_done = 1'b0;
      end
      repeat (8) @(negedge clk);
      chk("r n_full drained", r_n_full, 3'd0);
    end
    chk("r forwarded count", 32'(nfwd), 32'(nacc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bufpool_xbar.md
Name: bufpool_xbar

Overview:
- Parametrised successor to the fixed three-buffer agent/buffer MUX network in packetmem.
- Connects three agents (snooper, CPU, forwarder) to N_BUFS packet buffers.
- Owns the buffer lifecycle itself: a per-buffer ownership state machine, in-order ring pointers, a registered request/grant handshake, and a CPU accept/reject path.
- Select lines are generated internally rather than supplied from outside.

Parameters:
N_BUFS, 3, number of packet buffers; must be >= 2.
ADDR_WIDTH, 10, buffer address width.
WR_WIDTH, 64, write data width.
RD_WIDTH, 64, read data width.
PLEN_WIDTH, 32, packet length width.
Derived localparams: IDX_W = $clog2(N_BUFS), CNT_W = $clog2(N_BUFS+1).

Ports:
clk  in  1  clock; single clock domain.
rst  in  1  synchronous reset, active-high.
sn_req  in  1  snooper wants a buffer (level).
sn_gnt  out  1  snooper owns a buffer.
sn_done  in  1  pulse: snooper has finished writing its packet.
from_sn  in  ADDR_WIDTH+WR_WIDTH+1  {addr, wr_data, wr_en}.
cpu_req  in  1  CPU wants a buffer.
cpu_gnt  out  1  CPU owns a buffer.
cpu_acc  in  1  pulse: accept the packet.
cpu_rej  in  1  pulse: reject the packet.
from_cpu  in  ADDR_WIDTH+1  {addr, rd_en}.
to_cpu  out  RD_WIDTH+PLEN_WIDTH  {rd_data, packet_len}.
fwd_req  in  1  forwarder wants a buffer.
fwd_gnt  out  1  forwarder owns a buffer.
fwd_done  in  1  pulse: forwarding is complete.
from_fwd  in  ADDR_WIDTH+1  {addr, rd_en}.
to_fwd  out  RD_WIDTH+PLEN_WIDTH  {rd_data, packet_len}.
to_bufs  out  N_BUFS*(ADDR_WIDTH+WR_WIDTH+2)  per buffer {addr, wr_data, wr_en, rd_en}; buffer i occupies slice i.
from_bufs  in  N_BUFS*(RD_WIDTH+PLEN_WIDTH)  per buffer {rd_data, packet_len}; buffer i occupies slice i.
n_full  out  CNT_W  number of buffers in state FULL.

Behaviour:
- Per-buffer state: EMPTY, SN, FULL, CPU, PASS, DROP, FWD.
- Pointers: sn_ptr, cpu_ptr and fwd_ptr, each IDX_W bits. Each advances modulo N_BUFS (N_BUFS-1 wraps to 0), so packet order is preserved end to end.
- Reset (synchronous, at the clock edge):
  - all buffers go to EMPTY and all pointers to 0;
  - sn_gnt, cpu_gnt and fwd_gnt go to 0 and n_full to 0;
  - every enable in to_bufs is 0, and to_cpu/to_fwd are 0.
  - Reset mid-operation abandons all ownership with no completion events.
- Snooper grant: if sn_req && !sn_gnt && state[sn_ptr]==EMPTY, then at the next edge sn_gnt=1 and state[sn_ptr]=SN.
- CPU grant: same rule using cpu_req and cpu_ptr; requires state[cpu_ptr]==FULL, sets state to CPU.
- Forwarder grant: same rule using fwd_req and fwd_ptr; requires state[fwd_ptr]==PASS, sets state to FWD.
- Snooper release: sn_done while sn_gnt → state becomes FULL, sn_gnt=0, sn_ptr+1, all at the next edge.
- CPU release:
  - cpu_acc while cpu_gnt → state becomes PASS;
  - cpu_rej while cpu_gnt → state becomes DROP;
  - both asserted together → reject wins (DROP);
  - either way cpu_gnt=0 and cpu_ptr+1.
- Forwarder release: fwd_done while fwd_gnt → state becomes EMPTY, fwd_gnt=0, fwd_ptr+1.
- Drop reclaim: if state[fwd_ptr]==DROP and !fwd_gnt, then at the next edge state becomes EMPTY and fwd_ptr+1. fwd_req is irrelevant, no grant is issued, and each reclaim takes one cycle.
- Spurious inputs: done/acc/rej pulses while the corresponding gnt is 0 are ignored. A req deasserted after the grant does not revoke it.
- Grant spacing: after a release, that agent's gnt stays 0 for at least one full cycle before its next grant.
- Simultaneous events: release of buffer k by one agent and grant of buffer k to the next agent never happen in the same cycle, because the grant requires the post-release state. Events on different buffers in the same cycle are all applied.
- Ring discipline: the snooper stalls when state[sn_ptr] is not EMPTY. The snooper therefore never laps the forwarder, and all N_BUFS buffers can be FULL at once.
- Datapath (combinational from the registered state and pointers):
  - Buffer i in SN receives {from_sn, 1'b0}.
  - Buffer i in CPU receives {cpu addr, WR_WIDTH'b0, 1'b0, cpu rd_en}.
  - Buffer i in FWD receives {fwd addr, WR_WIDTH'b0, 1'b0, fwd rd_en}.
  - Buffer i in any other state receives all zeros.
  - to_cpu = from_bufs slice at cpu_ptr when cpu_gnt, else 0.
  - to_fwd = from_bufs slice at fwd_ptr when fwd_gnt, else 0.
- n_full: registered; equals the count of FULL buffers after each edge.

Test Plan:
- Reset, then a full lifecycle: sn_req on buffer 0 → sn_gnt=1 one cycle later; write addr 5, data 0xDEAD_BEEF → to_bufs slice 0 shows wr_en=1 and other slices are 0; sn_done → n_full=1; CPU granted buffer 0; cpu_acc → forwarder granted; fwd_done → buffer 0 EMPTY, all pointers = 1.
- Reject path: CPU rejects buffer 0 while fwd_req is low → buffer 0 returns to EMPTY one cycle after DROP, fwd_ptr=1, fwd_gnt never asserted.
- Saturation with N_BUFS=3: snooper fills 0,1,2 while CPU is idle → n_full=3, sn_req held with sn_gnt=0; cpu then fwd completes buffer 0 → snooper is granted buffer 0 (wrap-around).
- Simultaneous cpu_acc and cpu_rej → DROP. sn_done while sn_gnt=0 → no state change.
- Assert rst while all three agents are granted → next cycle every gnt=0, n_full=0, all to_bufs enables 0, pointers 0.
- N_BUFS=5 regression: 20 packets with random accept/reject → forwarder receives only accepted packets, in write order.
